// File: rtl/display_scanner.sv
// Time-multiplexed anode scanner: cycles through NUM_AN digit slots of a
// selectable window, with per-slot anti-ghost blanking and leading-zero suppression.
module display_scanner #(
  parameter int NUM_AN        = 4,
  parameter int NUM_WIN       = 2,
  parameter int CYC_PER_DIGIT = 2048,
  parameter int BLANK_CYC     = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [4*NUM_AN*NUM_WIN-1:0] digits,
  input  logic [NUM_AN*NUM_WIN-1:0]   dp_mask,
  input  logic [1:0]                  win_sel,
  input  logic                        lz_en,
  output logic [NUM_AN-1:0]           an,
  output logic [3:0]                  digit_out,
  output logic                        dp_n,
  output logic                        frame_start
);

  localparam int NDIG = NUM_AN * NUM_WIN;
  localparam int CW   = $clog2(CYC_PER_DIGIT);
  localparam int SW   = $clog2(NUM_AN);
  localparam logic [CW-1:0] CYC_LAST  = CW'(CYC_PER_DIGIT - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_AN - 1);

  typedef enum logic {BLANK, SHOW} phase_t;

  phase_t            state;
  phase_t            state_next;
  logic [CW-1:0]     cyc;
  logic [CW-1:0]     cyc_next;
  logic [SW-1:0]     slot;
  logic              fresh;

  logic [4*NDIG-1:0] digits_lat;
  logic [NDIG-1:0]   dp_lat;
  logic [1:0]        win_lat;
  logic              lz_lat;

  logic              boundary;
  logic [4*NDIG-1:0] digits_eff;
  logic [NDIG-1:0]   dp_eff;
  logic [1:0]        win_sel_eff;
  logic              lz_eff;
  int                win_idx;
  logic [4*NUM_AN-1:0] win_digits;
  logic [NUM_AN-1:0] win_dp;
  int                top_nz;
  logic [3:0]        cur_digit;
  logic              cur_dp;
  logic              suppress;

  // At the frame boundary the live inputs are used directly, so the first slot
  // of a frame already sees the data that is being latched for the whole frame.
  always_comb begin
    boundary    = (cyc == '0) && (slot == '0);
    digits_eff  = boundary ? digits  : digits_lat;
    dp_eff      = boundary ? dp_mask : dp_lat;
    win_sel_eff = boundary ? win_sel : win_lat;
    lz_eff      = boundary ? lz_en   : lz_lat;
    win_idx     = (int'(win_sel_eff) < NUM_WIN) ? int'(win_sel_eff) : 0;

    win_digits = '0;
    win_dp     = '0;
    for (int w = 0; w < NUM_WIN; w++) begin
      if (w == win_idx) begin
        for (int s = 0; s < NUM_AN; s++) begin
          win_digits[4*s +: 4] = digits_eff[4*(w*NUM_AN + s) +: 4];
          win_dp[s]            = dp_eff[w*NUM_AN + s];
        end
      end
    end

    top_nz = 0;
    for (int s = 0; s < NUM_AN; s++) begin
      if (win_digits[4*s +: 4] != 4'h0) top_nz = s;
    end

    cur_digit = 4'h0;
    cur_dp    = 1'b0;
    for (int s = 0; s < NUM_AN; s++) begin
      if (s == int'(slot)) begin
        cur_digit = win_digits[4*s +: 4];
        cur_dp    = win_dp[s];
      end
    end

    // slot > top_nz can never hold for slot 0, so the rightmost digit always shows
    suppress = lz_eff && (int'(slot) > top_nz) && !cur_dp;

    cyc_next   = (cyc == CYC_LAST) ? '0 : cyc + CW'(1);
    state_next = (int'(cyc_next) < BLANK_CYC) ? BLANK : SHOW;
  end

  // Counters, phase FSM, frame latches and registered outputs. The phase
  // register always describes the current cyc value, so outputs trail the
  // counter state by exactly one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc         <= '0;
      slot        <= '0;
      fresh       <= 1'b1;
      state       <= (BLANK_CYC == 0) ? SHOW : BLANK;
      digits_lat  <= '0;
      dp_lat      <= '0;
      win_lat     <= '0;
      lz_lat      <= 1'b0;
      an          <= '1;
      digit_out   <= 4'h0;
      dp_n        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      cyc   <= cyc_next;
      state <= state_next;
      fresh <= 1'b0;
      if (cyc == CYC_LAST) begin
        slot <= (slot == SLOT_LAST) ? '0 : slot + SW'(1);
      end

      if (boundary) begin
        digits_lat <= digits;
        dp_lat     <= dp_mask;
        win_lat    <= win_sel;
        lz_lat     <= lz_en;
      end

      // The post-reset 0/0 state is not a wrap, so it produces no pulse.
      frame_start <= boundary && !fresh;

      case (state)
        BLANK: begin
          an   <= '1;
          dp_n <= 1'b1;
        end
        SHOW: begin
          if (suppress) begin
            an   <= '1;
            dp_n <= 1'b1;
          end else begin
            an        <= ~(NUM_AN'(1) << slot);
            digit_out <= cur_digit;
            dp_n      <= ~cur_dp;
          end
        end
        default: begin
          an   <= '1;
          dp_n <= 1'b1;
        end
      endcase
    end
  end

endmodule
